l2_writeback_buffer: RTL and testbench

Single-entry write-back buffer between the L2 cache ways and physical memory. It takes a dirty victim line (tag, set, 256-bit data) read out of an L2 way on eviction, drains it to physical memory as a 4-beat 64-bit burst write, and exposes a lookup port. The lookup port lets the L2 controller service a miss to a line that is still buffered.

---
 rtl/l2_writeback_buffer_if.sv | 31 +++
 rtl/l2_writeback_buffer.sv | 81 ++++++++
 tb/tb_l2_writeback_buffer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_writeback_buffer_if.sv
// Bundle of the eviction, lookup and physical-memory signals of the L2 write-back buffer.
//   slave  : the buffer itself (receives victims/lookups/pmem_resp, drives status and burst)
//   master : the environment (L2 controller plus physical memory)
interface l2_writeback_buffer_if;
  logic         evict_valid;
  logic [23:0]  evict_tag;
  logic [2:0]   evict_set;
  logic [255:0] evict_line;
  logic         evict_ready;
  logic [23:0]  lookup_tag;
  logic [2:0]   lookup_set;
  logic         lookup_hit;
  logic [255:0] lookup_line;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_burst_out;
  logic         pmem_write;
  logic         pmem_resp;
  logic         wb_done;

  modport master (
    output evict_valid, evict_tag, evict_set, evict_line, lookup_tag, lookup_set, pmem_resp,
    input  evict_ready, lookup_hit, lookup_line, pmem_address, pmem_burst_out, pmem_write,
           wb_done
  );

  modport slave (
    input  evict_valid, evict_tag, evict_set, evict_line, lookup_tag, lookup_set, pmem_resp,
    output evict_ready, lookup_hit, lookup_line, pmem_address, pmem_burst_out, pmem_write,
           wb_done
  );
endinterface

// File: rtl/l2_writeback_buffer.sv
// Single-entry write-back buffer between the L2 ways and physical memory.
// Captures one dirty victim (tag, set, 256-bit line), drains it as a 4-beat 64-bit burst
// write and lets the controller look up the buffered line while it is draining.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of l2_writeback_buffer_if (eviction, lookup and pmem signals)
module l2_writeback_buffer (
  input logic              clk,
  input logic              rst,
  l2_writeback_buffer_if.slave bus
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e       state_q, state_d;
  logic [23:0]  tag_q, tag_d;
  logic [2:0]   set_q, set_d;
  logic [255:0] line_q, line_d;
  logic [1:0]   beat_q, beat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
      set_q   <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    set_d           = set_q;
    line_d          = line_q;
    beat_d          = beat_q;
    bus.evict_ready = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.wb_done     = 1'b0;
    case (state_q)
      StIdle: begin
        bus.evict_ready = 1'b1;
        if (bus.evict_valid) begin
          tag_d   = bus.evict_tag;
          set_d   = bus.evict_set;
          line_d  = bus.evict_line;
          beat_d  = 2'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          if (beat_q == 2'd3) begin
            // Final beat acknowledged: release the entry; no capture this cycle.
            bus.wb_done = 1'b1;
            beat_d      = 2'd0;
            state_d     = StIdle;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.pmem_address   = {tag_q, set_q, 5'b0};
  assign bus.pmem_burst_out = line_q[{beat_q, 6'b0} +: 64];
  assign bus.lookup_hit     = (state_q == StWrite) && (tag_q == bus.lookup_tag) &&
                              (set_q == bus.lookup_set);
  assign bus.lookup_line    = line_q;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
module tb_l2_writeback_buffer;

  logic clk;
  logic rst;
  l2_writeback_buffer_if bus ();

  l2_writeback_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model: is an entry held, what it holds, how many beats acknowledged so far.
  bit           m_busy;
  logic [23:0]  m_tag;
  logic [2:0]   m_set;
  logic [255:0] m_line;
  int           m_beats;

  // Inputs change only just after a rising edge (or mid-cycle for reset), so at the falling
  // edge the outputs are settled and the model can also decide the effect of the next edge.
  always @(negedge clk) begin
    logic         e_hit;
    logic         e_done;
    logic [63:0]  e_burst;
    if (rst) begin
      m_busy  = 1'b0;
      m_tag   = '0;
      m_set   = '0;
      m_line  = '0;
      m_beats = 0;
    end
    e_hit   = m_busy && (m_tag == bus.lookup_tag) && (m_set == bus.lookup_set);
    e_done  = m_busy && bus.pmem_resp && (m_beats == 3);
    e_burst = 64'(m_line >> (64 * m_beats));
    chk1("evict_ready", bus.evict_ready, !m_busy);
    chk1("pmem_write", bus.pmem_write, m_busy);
    chk1("wb_done", bus.wb_done, e_done);
    chk1("lookup_hit", bus.lookup_hit, e_hit);
    chkw("pmem_address", 256'(bus.pmem_address), 256'({m_tag, m_set, 5'b0}));
    if (m_busy) chkw("pmem_burst_out", 256'(bus.pmem_burst_out), 256'(e_burst));
    if (e_hit) chkw("lookup_line", bus.lookup_line, m_line);
    if (!rst) begin
      if (!m_busy) begin
        if (bus.evict_valid) begin
          m_busy  = 1'b1;
          m_tag   = bus.evict_tag;
          m_set   = bus.evict_set;
          m_line  = bus.evict_line;
          m_beats = 0;
        end
      end else if (bus.pmem_resp) begin
        if (m_beats == 3) begin
          m_busy  = 1'b0;
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic evict(input logic [23:0] t, input logic [2:0] s, input logic [255:0] l);
    bus.evict_valid = 1'b1;
    bus.evict_tag   = t;
    bus.evict_set   = s;
    bus.evict_line  = l;
  endtask

  logic [255:0] line_a, line_w, line_b1, line_b2, line_c, line_d;
  logic [63:0]  exp_beats [4];
  int           dones, beats;

  initial begin
    rst             = 1'b1;
    bus.evict_valid = 1'b0;
    bus.evict_tag   = '0;
    bus.evict_set   = '0;
    bus.evict_line  = '0;
    bus.lookup_tag  = '0;
    bus.lookup_set  = '0;
    bus.pmem_resp   = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk1("reset evict_ready", bus.evict_ready, 1'b1);
    chk1("reset pmem_write", bus.pmem_write, 1'b0);
    chk1("reset lookup_hit", bus.lookup_hit, 1'b0);
    chk1("reset wb_done", bus.wb_done, 1'b0);
    chkw("reset pmem_address", 256'(bus.pmem_address), 256'(32'h0));

    // Basic drain with fixed, hand-written values.
    line_a = {64'h3333333333333333, 64'h2222222222222222,
              64'h1111111111111111, 64'h0000000000000000};
    exp_beats = '{64'h0000000000000000, 64'h1111111111111111,
                  64'h2222222222222222, 64'h3333333333333333};
    step();
    evict(24'hABCDEF, 3'd5, line_a);
    step();
    bus.evict_valid = 1'b0;
    bus.lookup_tag  = 24'hABCDEF;
    bus.lookup_set  = 3'd5;
    #1;
    chk1("drain pmem_write", bus.pmem_write, 1'b1);
    chkw("drain address", 256'(bus.pmem_address), 256'(32'hABCDEFA0));
    chk1("lookup hit", bus.lookup_hit, 1'b1);
    chkw("lookup line", bus.lookup_line, line_a);
    bus.lookup_set = 3'd4;
    #1 chk1("lookup wrong set", bus.lookup_hit, 1'b0);
    bus.lookup_tag = 24'hABCDEE;
    bus.lookup_set = 3'd5;
    #1 chk1("lookup wrong tag", bus.lookup_hit, 1'b0);
    bus.lookup_tag = 24'hABCDEF;
    step();
    bus.pmem_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chkw("drain beat", 256'(bus.pmem_burst_out), 256'(exp_beats[i]));
      chk1("drain wb_done", bus.wb_done, i == 3);
      chk1("drain hit held", bus.lookup_hit, 1'b1);
      step();
    end
    bus.pmem_resp = 1'b0;
    #1;
    chk1("after drain ready", bus.evict_ready, 1'b1);
    chk1("after drain write", bus.pmem_write, 1'b0);
    chk1("after drain hit", bus.lookup_hit, 1'b0);
    step();

    // Wait states: three idle cycles before each acknowledge.
    line_w = rnd_line();
    evict(24'h123456, 3'd2, line_w);
    step();
    bus.evict_valid = 1'b0;
    dones = 0;
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        bus.pmem_resp = 1'b0;
        #1;
        chkw("wait beat stable", 256'(bus.pmem_burst_out), 256'(line_w[64*b +: 64]));
        chkw("wait addr stable", 256'(bus.pmem_address), 256'(32'h12345640));
        dones += int'(bus.wb_done);
        step();
      end
      bus.pmem_resp = 1'b1;
      #1;
      chkw("wait beat acked", 256'(bus.pmem_burst_out), 256'(line_w[64*b +: 64]));
      beats += int'(bus.pmem_resp && bus.pmem_write);
      dones += int'(bus.wb_done);
      step();
    end
    bus.pmem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 dones += int'(bus.wb_done);
      beats += int'(bus.pmem_resp && bus.pmem_write);
      step();
    end
    chkw("wait wb_done count", 256'(dones), 256'(1));
    chkw("wait beat count", 256'(beats), 256'(4));

    // Busy eviction: a second victim is held throughout the first burst.
    line_b1 = rnd_line();
    line_b2 = rnd_line();
    evict(24'h0A0A0A, 3'd1, line_b1);
    step();
    evict(24'hB0B0B0, 3'd6, line_b2);
    bus.pmem_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chkw("busy addr first", 256'(bus.pmem_address), 256'({24'h0A0A0A, 3'd1, 5'b0}));
      chkw("busy beat first", 256'(bus.pmem_burst_out), 256'(line_b1[64*i +: 64]));
      step();
    end
    bus.pmem_resp = 1'b0;
    #1;
    chk1("busy idle ready", bus.evict_ready, 1'b1);
    chk1("busy idle write", bus.pmem_write, 1'b0);
    step();
    bus.evict_valid = 1'b0;
    #1;
    chk1("busy second write", bus.pmem_write, 1'b1);
    chkw("busy addr second", 256'(bus.pmem_address), 256'({24'hB0B0B0, 3'd6, 5'b0}));
    chkw("busy beat second", 256'(bus.pmem_burst_out), 256'(line_b2[63:0]));
    bus.pmem_resp = 1'b1;
    repeat (4) step();
    bus.pmem_resp = 1'b0;
    step();

    // Reset in the middle of a burst, after beat 1 is acknowledged.
    line_c = rnd_line();
    evict(24'hC0FFEE, 3'd3, line_c);
    step();
    bus.evict_valid = 1'b0;
    bus.lookup_tag  = 24'hC0FFEE;
    bus.lookup_set  = 3'd3;
    bus.pmem_resp   = 1'b1;
    repeat (2) step();
    bus.pmem_resp = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("async rst write", bus.pmem_write, 1'b0);
    chk1("async rst ready", bus.evict_ready, 1'b1);
    chk1("async rst hit", bus.lookup_hit, 1'b0);
    chk1("async rst wb_done", bus.wb_done, 1'b0);
    step();
    rst = 1'b0;
    #1 chk1("post rst wb_done", bus.wb_done, 1'b0);
    line_d = rnd_line();
    evict(24'h00D00D, 3'd7, line_d);
    step();
    bus.evict_valid = 1'b0;
    #1;
    chk1("restart write", bus.pmem_write, 1'b1);
    chkw("restart beat0", 256'(bus.pmem_burst_out), 256'(line_d[63:0]));
    bus.pmem_resp = 1'b1;
    repeat (4) step();
    bus.pmem_resp = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.evict_valid = ($urandom_range(0, 2) == 0);
      bus.evict_tag   = 24'($urandom);
      bus.evict_set   = 3'($urandom);
      bus.evict_line  = rnd_line();
      bus.pmem_resp   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin
          bus.lookup_tag = m_tag;
          bus.lookup_set = m_set;
        end
        1: begin
          bus.lookup_tag = m_tag;
          bus.lookup_set = m_set + 3'd1;
        end
        default: begin
          bus.lookup_tag = 24'($urandom);
          bus.lookup_set = 3'($urandom);
        end
      endcase
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
